// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: FSM encoding, default widths
// and the ALUFun codes used by benches and requesters.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_DW   = 32;
    localparam int DEF_FUNW = 6;

    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: selects the first valid requester strictly
// after last_grant, wrapping modulo NREQ.
module alu_rr_picker #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any_valid
);

    // Offsets run 1..NREQ so last_grant itself is considered last, which lets
    // a lone requester win repeatedly.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_valid && req_valid[(int'(last_grant) + k) % NREQ]) begin
                any_valid = 1'b1;
                grant_idx = IDXW'((int'(last_grant) + k) % NREQ);
            end
        end
        if (any_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional per-requester grant counters are enabled with ALU_ARB_STATS_EN.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int FUNW = DEF_FUNW,
    parameter int NREQ = 2,
    parameter int IDW  = 3,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ*FUNW-1:0] req_fun,
    input  logic [NREQ-1:0]      req_sign,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [FUNW-1:0]      alu_fun,
    output logic                 alu_sign,
    input  logic [DW-1:0]        alu_z,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DW-1:0]        resp_data,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy,
    input  logic                 stat_clr,
    output logic [NREQ*CNTW-1:0] stat_grant_cnt
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t      state;
    arb_state_t      next_state;
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] cur_id;
    logic [NREQ-1:0] grant;
    logic [IDXW-1:0] grant_idx;
    logic            any_valid;
    logic            accept;

    alu_rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_valid  (any_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req_ready is gated by reset so it reads zero while reset is held.
    always_comb begin
        accept    = (state == IDLE) && any_valid && reset;
        req_ready = accept ? grant : '0;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fun    <= '0;
            alu_sign   <= 1'b0;
            cur_id     <= '0;
            last_grant <= IDXW'(NREQ - 1);
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= req_a[grant_idx*DW +: DW];
                alu_b      <= req_b[grant_idx*DW +: DW];
                alu_fun    <= req_fun[grant_idx*FUNW +: FUNW];
                alu_sign   <= req_sign[grant_idx];
                cur_id     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == ISSUE) begin
                resp_data  <= alu_z;
                resp_id    <= IDW'(cur_id);
                resp_valid <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NREQ*CNTW-1:0] grant_cnt;

    // Saturating grant counters; a coincident clear beats the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
        end else if (stat_clr) begin
            grant_cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && grant_cnt[i*CNTW +: CNTW] != {CNTW{1'b1}}) begin
                    grant_cnt[i*CNTW +: CNTW] <= grant_cnt[i*CNTW +: CNTW] + CNTW'(1);
                end
            end
        end
    end

    assign stat_grant_cnt = grant_cnt;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model; stats
// checks run only when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int DW   = 32;
    localparam int FUNW = 6;
    localparam int NREQ = 2;
    localparam int IDW  = 3;
`ifdef ALU_ARB_STATS_EN
    localparam int CNTW = 4;
`else
    localparam int CNTW = 16;
`endif

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ*FUNW-1:0] req_fun;
    logic [NREQ-1:0]      req_sign;
    logic [DW-1:0]        alu_a;
    logic [DW-1:0]        alu_b;
    logic [FUNW-1:0]      alu_fun;
    logic                 alu_sign;
    logic [DW-1:0]        alu_z;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DW-1:0]        resp_data;
    logic [IDW-1:0]       resp_id;
    logic                 busy;
    logic                 stat_clr;
    logic [NREQ*CNTW-1:0] stat_grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(
        .DW   (DW),
        .FUNW (FUNW),
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_fun        (req_fun),
        .req_sign       (req_sign),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_fun        (alu_fun),
        .alu_sign       (alu_sign),
        .alu_z          (alu_z),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .busy           (busy),
        .stat_clr       (stat_clr),
        .stat_grant_cnt (stat_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_z = '0;
        case (alu_fun)
            FUN_ADD: alu_z = alu_a + alu_b;
            FUN_SUB: alu_z = alu_a - alu_b;
            FUN_AND: alu_z = alu_a & alu_b;
            FUN_OR:  alu_z = alu_a | alu_b;
            default: alu_z = '0;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [FUNW-1:0] fun, input logic sign);
        req_a[idx*DW +: DW]       = a;
        req_b[idx*DW +: DW]       = b;
        req_fun[idx*FUNW +: FUNW] = fun;
        req_sign[idx]             = sign;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_op(input logic [NREQ-1:0] v);
        req_valid  = v;
        resp_ready = 1'b1;
        step(1);
        req_valid = '0;
        step(2);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_fun    = '0;
        req_sign   = '0;
        resp_ready = 1'b0;
        stat_clr   = 1'b0;

        // Reset state, including req_ready held low with a request pending.
        step(1);
        req_valid = 2'b01;
        #1;
        check_output("rst_req_ready", req_ready, 0);
        check_output("rst_alu_a", alu_a, 0);
        check_output("rst_alu_sign", alu_sign, 0);
        check_output("rst_resp_valid", resp_valid, 0);
        check_output("rst_resp_data", resp_data, 0);
        check_output("rst_resp_id", resp_id, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_stat", stat_grant_cnt, 0);
        req_valid = '0;
        step(1);
        reset = 1'b1;

        // Single ADD from requester 0.
        $display("[TB] single request ADD");
        apply_stimulus(0, 5, 3, FUN_ADD, 1'b1);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        #1;
        check_output("add_req_ready", req_ready, 2'b01);
        step(1);
        req_valid = '0;
        check_output("add_alu_a", alu_a, 5);
        check_output("add_alu_b", alu_b, 3);
        check_output("add_alu_fun", alu_fun, FUN_ADD);
        check_output("add_alu_sign", alu_sign, 1);
        check_output("add_busy_issue", busy, 1);
        check_output("add_resp_valid_issue", resp_valid, 0);
        step(1);
        check_output("add_resp_valid", resp_valid, 1);
        check_output("add_resp_data", resp_data, 8);
        check_output("add_resp_id", resp_id, 0);
        step(1);
        check_output("add_busy_done", busy, 0);
        check_output("add_resp_valid_done", resp_valid, 0);
        check_output("add_alu_a_hold", alu_a, 5);

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        $display("[TB] contention");
        reset = 1'b0;
        #1;
        reset = 1'b1;
        apply_stimulus(0, 10, 4, FUN_SUB, 1'b0);
        apply_stimulus(1, 1, 1, FUN_ADD, 1'b0);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output("rr_req_ready", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            step(1);
            check_output("rr_alu_a", alu_a, (k % 2 == 1) ? 1 : 10);
            step(1);
            check_output("rr_resp_valid", resp_valid, 1);
            check_output("rr_resp_data", resp_data, (k % 2 == 1) ? 2 : 6);
            check_output("rr_resp_id", resp_id, k % 2);
            step(1);
        end

        // Backpressure: response held for 5 cycles, no new grants meanwhile.
        $display("[TB] backpressure");
        resp_ready = 1'b0;
        #1;
        check_output("bp_req_ready_first", req_ready, 2'b01);
        step(2);
        for (int k = 0; k < 5; k++) begin
            check_output("bp_resp_valid", resp_valid, 1);
            check_output("bp_resp_data", resp_data, 6);
            check_output("bp_resp_id", resp_id, 0);
            check_output("bp_req_ready", req_ready, 0);
            check_output("bp_busy", busy, 1);
            step(1);
        end
        resp_ready = 1'b1;
        #1;
        check_output("bp_resp_valid_hs", resp_valid, 1);
        step(1);
        check_output("bp_next_grant", req_ready, 2'b10);
        step(1);
        req_valid = '0;
        check_output("bp_next_alu_a", alu_a, 1);
        step(1);
        check_output("bp_next_resp_id", resp_id, 1);
        check_output("bp_next_resp_data", resp_data, 2);
        step(1);

        // Reset during ISSUE discards the operation.
        $display("[TB] reset mid-op");
        req_valid = 2'b10;
        step(1);
        req_valid = '0;
        check_output("mid_busy_issue", busy, 1);
        reset = 1'b0;
        #1;
        check_output("mid_alu_a", alu_a, 0);
        check_output("mid_alu_b", alu_b, 0);
        check_output("mid_alu_fun", alu_fun, 0);
        check_output("mid_busy", busy, 0);
        check_output("mid_resp_valid", resp_valid, 0);
        check_output("mid_resp_data", resp_data, 0);
        check_output("mid_resp_id", resp_id, 0);
        check_output("mid_req_ready", req_ready, 0);
        step(1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_output("mid_no_resp", resp_valid, 0);
        end
        req_valid = 2'b11;
        #1;
        check_output("mid_first_grant", req_ready, 2'b01);
        step(1);
        req_valid = '0;
        step(1);
        check_output("mid_resp_id", resp_id, 0);
        check_output("mid_resp_data_after", resp_data, 6);
        step(1);

        // Withdrawal: requester 1 gives up while requester 0 is served.
        $display("[TB] withdrawal");
        req_valid = 2'b01;
        #1;
        check_output("wd_repeat_win", req_ready, 2'b01);
        step(1);
        req_valid  = 2'b10;
        resp_ready = 1'b0;
        #1;
        check_output("wd_ready_issue", req_ready, 0);
        step(1);
        check_output("wd_ready_resp", req_ready, 0);
        check_output("wd_resp_id", resp_id, 0);
        req_valid  = '0;
        resp_ready = 1'b1;
        step(1);
        check_output("wd_idle", busy, 0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_output("wd_no_op", busy, 0);
            check_output("wd_no_resp", resp_valid, 0);
            check_output("wd_alu_a_stable", alu_a, 10);
            check_output("wd_resp_id_hold", resp_id, 0);
        end

`ifdef ALU_ARB_STATS_EN
        $display("[TB] grant statistics");
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step(1);
        for (int k = 0; k < 3; k++) do_op(2'b01);
        for (int k = 0; k < 2; k++) do_op(2'b10);
        check_output("stat_cnt0", stat_grant_cnt[0 +: CNTW], 3);
        check_output("stat_cnt1", stat_grant_cnt[CNTW +: CNTW], 2);
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        check_output("stat_clr_cnt0", stat_grant_cnt[0 +: CNTW], 0);
        check_output("stat_clr_cnt1", stat_grant_cnt[CNTW +: CNTW], 0);
        stat_clr  = 1'b1;
        req_valid = 2'b01;
        step(1);
        stat_clr  = 1'b0;
        req_valid = '0;
        step(2);
        check_output("stat_clr_wins", stat_grant_cnt[0 +: CNTW], 0);
        for (int k = 0; k < 20; k++) do_op(2'b01);
        check_output("stat_saturate", stat_grant_cnt[0 +: CNTW], 15);
        check_output("stat_other_zero", stat_grant_cnt[CNTW +: CNTW], 0);
`else
        check_output("stat_tied_zero", stat_grant_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (operands A/B, 6-bit ALUFun, Sign, result Z) between NREQ requesters, e.g. the pipeline EX stage, a multi-cycle mul/div sequencer and a debug port.
- Accepts requests over a valid/ready handshake and arbitrates round-robin.
- Drives registered operands to the ALU, captures Z one cycle later and returns the result with the requester ID over a valid/ready response channel.

Parameters:
- DW, 32, operand/result width.
- FUNW, 6, ALUFun width.
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, 3, response ID width; must satisfy 2^IDW >= NREQ.
- CNTW, 16, grant-counter width (optional feature only).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW].
- req_b  in  NREQ*DW  operand B, same packing.
- req_fun  in  NREQ*FUNW  ALUFun code per requester.
- req_sign  in  NREQ  signed-compare/overflow select per requester.
- alu_a  out  DW  registered operand A to ALU.
- alu_b  out  DW  registered operand B to ALU.
- alu_fun  out  FUNW  registered ALUFun to ALU.
- alu_sign  out  1  registered Sign to ALU.
- alu_z  in  DW  ALU result (combinational from alu_*).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DW  captured ALU result.
- resp_id  out  IDW  index of the requester that owns resp_data.
- busy  out  1  high whenever state != IDLE.
- stat_clr  in  1  synchronous clear of grant counters.
- stat_grant_cnt  out  NREQ*CNTW  per-requester grant counts.

Behaviour:
- FSM states:
  - IDLE: if any req_valid, assert req_ready for the winner only. At the edge, latch the winner's a/b/fun/sign into alu_*, record the ID, update the RR pointer, go to ISSUE.
  - ISSUE: exactly one cycle; ALU settles. At the edge, capture alu_z into resp_data and the ID into resp_id, set resp_valid, go to RESP.
  - RESP: hold resp_valid/resp_data/resp_id stable until resp_ready. On the handshake edge, clear resp_valid and go to IDLE.
- Latency: acceptance at edge N, alu_* valid during cycle N+1, resp_valid high from edge N+2. Minimum 3 cycles per operation.
- Throughput: req_ready is only asserted in IDLE; there is no overlap between operations.
- Round-robin:
  - Pointer last_grant resets to NREQ-1, so requester 0 wins first.
  - The winner is the first valid index strictly after last_grant, wrapping modulo NREQ.
  - A single valid requester always wins, including repeat wins by the same requester.
- Requester rule: a/b/fun/sign must stay stable while req_valid is high and req_ready is low. Deasserting req_valid before acceptance is legal and is a withdrawal.
- Stability: alu_* hold their last value outside ISSUE, with no toggling while idle.
- Reset values, applied immediately on reset low:
  - state = IDLE.
  - req_ready = 0; alu_a, alu_b, alu_fun, alu_sign = 0.
  - resp_valid = 0; resp_data = 0; resp_id = 0.
  - busy = 0; last_grant = NREQ-1; counters = 0.
- Reset mid-operation: the in-flight op is discarded with no response; requesters must re-issue.
- resp_ready while resp_valid is low is ignored.
- req_fun is passed through unchecked; undefined codes are the ALU's problem.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - One saturating CNTW-bit counter per requester, incremented on each accept edge for the granted index; it holds at all-ones.
  - stat_clr zeroes all counters; when stat_clr coincides with a grant, clear wins.
- Undefined: stat_grant_cnt is tied to 0, stat_clr is ignored, and no counter flops are present.

Decomposition:
- Package alu_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - default DW/FUNW constants;
  - the ALUFun code constants used by benches (ADD=6'b000000, SUB=6'b000001, AND=6'b011000, OR=6'b011110).
- Sub-module alu_rr_picker: purely combinational; inputs req_valid and last_grant, outputs one-hot grant, grant index and any_valid. It is reused by other shared-resource arbiters.

Test Plan:
- Single request, ADD: requester 0 sends A=5, B=3, fun=ADD, sign=1, with resp_ready held high. Required: alu_a=5 and alu_b=3 in cycle N+1; resp_valid at N+2 with resp_data=8, resp_id=0; busy low again at N+3.
- Contention: requesters 0 and 1 both valid from reset, 0 doing SUB 10-4 and 1 doing ADD 1+1. Required: grant 0 first (resp 6, id 0), then 1 (resp 2, id 1); with both held valid, grants alternate 0,1,0,1.
- Backpressure: resp_ready low for 5 cycles after resp_valid. Required: resp_data/resp_id stable, req_ready=0 throughout; the next grant occurs the cycle after the handshake.
- Reset mid-op: assert reset during ISSUE. Required: all outputs 0 asynchronously; no response after release; requester 0 granted first again.
- Withdrawal: requester 1 drops req_valid before acceptance while requester 0 is busy. Required: no op issued for requester 1, no resp_id=1.
- Stats (ALU_ARB_STATS_EN): 3 grants to requester 0 and 2 to requester 1. Required: counts 3 and 2; after stat_clr, both 0; with CNTW=4 and 20 grants, the count saturates at 15.
